ldo_power_sequencer: RTL and testbench
======================================

Name: ldo_power_sequencer

Overview:
- Sequences enable lines of N on-chip 1.8 V LDO regulators, one channel at a time. Power-down always precedes power-up.
- Waits for each regulator's power-good before moving on. Disables and flags any channel that fails to come up or later drops out.
- Sits in the user project area on the Wishbone clock. Requests come from logic-analyzer/config bits; enables drive the LDO `en` pins.

Parameters:
- N_LDO, 3, number of regulator channels.
- STAGGER_CYC, 1000, minimum cycles a channel spends in PG_WAIT or OFF_WAIT (settle/discharge spacing); must be >= 1.
- PG_TIMEOUT, 50000, cycles allowed from enable to power-good before fault; must be > STAGGER_CYC.
- CNT_W, 16, counter width; must hold PG_TIMEOUT.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  asynchronous active-high reset
- req_i  input  N_LDO  requested on/off state per channel (level)
- pgood_i  input  N_LDO  asynchronous power-good per channel from regulator comparators
- fault_clr_i  input  N_LDO  per-channel fault clear (one-cycle pulse)
- en_o  output  N_LDO  regulator enables
- settled_o  output  N_LDO  channel enabled and power-good confirmed
- fault_o  output  N_LDO  sticky per-channel fault
- busy_o  output  1  FSM not in IDLE
- irq_o  output  1  one-cycle pulse when any fault bit sets

Behaviour:
- Reset: en_o, settled_o, fault_o = 0; irq_o = 0; busy_o = 0; FSM = IDLE; counter = 0; pgood synchronizers = 0.
- pgood_i passes through a 2-flop synchronizer (pg_s). All references below use pg_s, so 2-cycle input latency.
- States: IDLE, PG_WAIT, OFF_WAIT. busy_o = (state != IDLE). Active channel index k is registered on entry.
- IDLE, evaluated each cycle in this priority:
  - (1) off-set = en_o & ~req_i non-zero: take highest index k; next cycle en_o[k]=0, settled_o[k]=0, cnt=0, go OFF_WAIT.
  - (2) else on-set = req_i & ~en_o & ~fault_o non-zero: take lowest index k; next cycle en_o[k]=1, cnt=0, go PG_WAIT.
  - (3) else stay.
- PG_WAIT, cnt increments every cycle, saturating at PG_TIMEOUT-1:
  - req_i[k]=0: en_o[k]=0, cnt=0, go OFF_WAIT (abort, no fault).
  - else pg_s[k]=1 and cnt >= STAGGER_CYC-1: settled_o[k]=1, go IDLE.
  - else cnt == PG_TIMEOUT-1: en_o[k]=0, fault_o[k]=1, irq_o pulse, go IDLE.
- OFF_WAIT: cnt increments; at cnt == STAGGER_CYC-1 go IDLE. Requests are ignored until then.
- Brown-out monitor, any state, every channel i with settled_o[i]=1 and pg_s[i]=0:
  - next cycle en_o[i]=0, settled_o[i]=0, fault_o[i]=1, irq_o pulse.
  - No FSM transition; if i==k the FSM is unaffected because settled_o[k] is 0 in PG_WAIT.
- Fault clear: fault_clr_i[i] clears fault_o[i] next cycle. A fault set in the same cycle wins over the clear. A faulted channel is never re-enabled until cleared, even with req_i[i]=1.
- irq_o is the OR of all fault set events in that cycle, asserted for exactly one cycle.
- Reset mid-operation drops all enables immediately (asynchronous). No discharge wait is enforced after reset release.
- At most one channel changes en_o per sequencing step. Simultaneous requests are serialized in the index order above.

Test Plan:
- req_i 000->111, pg_s asserted 10 cycles after each en -> en_o bits set in order 0,1,2. Spacing between enables = STAGGER_CYC+1 cycles (+1 IDLE cycle). settled_o ends 111, fault_o=000.
- From all on, req_i -> 000 -> en_o clears in order 2,1,0, each OFF_WAIT lasting STAGGER_CYC cycles. busy_o low afterwards.
- req_i[1]=1, pgood_i[1] held 0 -> en_o[1] drops exactly PG_TIMEOUT cycles after rising; fault_o[1]=1; one irq_o pulse. Holding req_i keeps it off until a fault_clr_i[1] pulse, after which it re-sequences.
- Channel 0 settled, then pgood_i[0] drops -> en_o[0]=0 and fault_o[0]=1 three cycles later (2 sync + 1); irq_o one-cycle pulse; other channels untouched.
- req_i[2] dropped at PG_WAIT cnt=20 -> en_o[2]=0 next cycle, OFF_WAIT entered, no fault. Separately: reset asserted mid PG_WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ldo_power_sequencer_if.sv
// Request/status bundle between LDO sequencer and its config/regulator side.
// Latency: none, wires only.
// Backpressure: none; requests are levels, status is continuously driven.
interface ldo_power_sequencer_if #(
  parameter int N_LDO = 3
);
  logic [N_LDO-1:0] req_i;
  logic [N_LDO-1:0] pgood_i;
  logic [N_LDO-1:0] fault_clr_i;
  logic [N_LDO-1:0] en_o;
  logic [N_LDO-1:0] settled_o;
  logic [N_LDO-1:0] fault_o;
  logic             busy_o;
  logic             irq_o;

  // Requesting side: config bits, regulator comparators, fault clears.
  modport master (
    output req_i, pgood_i, fault_clr_i,
    input  en_o, settled_o, fault_o, busy_o, irq_o
  );

  // Sequencer side.
  modport slave (
    input  req_i, pgood_i, fault_clr_i,
    output en_o, settled_o, fault_o, busy_o, irq_o
  );
endinterface

// File: rtl/ldo_power_sequencer.sv
// One-at-a-time LDO enable sequencer: power-down before power-up, power-good wait, brown-out fault.
// Latency: pgood 2-cycle sync; enable changes 1 cycle after IDLE decision; settle >= STAGGER_CYC cycles.
// Backpressure: none; requests are levels, ignored while a channel is waiting, then serialized by index.
module ldo_power_sequencer #(
  parameter int N_LDO       = 3,
  parameter int STAGGER_CYC = 1000,
  parameter int PG_TIMEOUT  = 50000,
  parameter int CNT_W       = 16
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  ldo_power_sequencer_if.slave bus
);

  localparam int IDX_W = (N_LDO > 1) ? $clog2(N_LDO) : 1;
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] PG_LAST   = CNT_W'(PG_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PG_WAIT, OFF_WAIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_LDO-1:0] pg_meta, pg_s;
  logic [N_LDO-1:0] en_q, en_d;
  logic [N_LDO-1:0] settled_q, settled_d;
  logic [N_LDO-1:0] fault_q, fault_d;
  logic [N_LDO-1:0] fault_set;
  logic [N_LDO-1:0] brownout;
  logic             irq_q, irq_d;

  logic [N_LDO-1:0] off_set, on_set;
  logic [IDX_W-1:0] off_idx, on_idx;
  logic             pg_abort, pg_done, pg_tmo, off_done;

  // Two-flop synchronizer for the asynchronous comparator outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pg_meta <= '0;
      pg_s    <= '0;
    end else begin
      pg_meta <= bus.pgood_i;
      pg_s    <= pg_meta;
    end
  end

  // Channels waiting to go down and channels eligible to come up.
  assign off_set  = en_q & ~bus.req_i;
  assign on_set   = bus.req_i & ~en_q & ~fault_q;
  assign brownout = settled_q & ~pg_s;

  // Power-down picks the highest index, power-up the lowest.
  always_comb begin
    off_idx = '0;
    on_idx  = '0;
    for (int i = 0; i < N_LDO; i++) begin
      if (off_set[i]) off_idx = IDX_W'(i);
    end
    for (int i = N_LDO - 1; i >= 0; i--) begin
      if (on_set[i]) on_idx = IDX_W'(i);
    end
  end

  // Decoded wait-state outcomes shared by next-state and output logic.
  assign pg_abort = (state_q == PG_WAIT) && !bus.req_i[k_q];
  assign pg_done  = (state_q == PG_WAIT) && bus.req_i[k_q] && pg_s[k_q] && (cnt_q >= STAG_LAST);
  assign pg_tmo   = (state_q == PG_WAIT) && bus.req_i[k_q] && !(pg_s[k_q] && (cnt_q >= STAG_LAST))
                    && (cnt_q == PG_LAST);
  assign off_done = (state_q == OFF_WAIT) && (cnt_q == STAG_LAST);

  // FSM state, active channel and spacing counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: IDLE arbitrates, wait states count until an exit condition.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|off_set) begin
          state_d = OFF_WAIT;
          k_d     = off_idx;
          cnt_d   = '0;
        end else if (|on_set) begin
          state_d = PG_WAIT;
          k_d     = on_idx;
          cnt_d   = '0;
        end
      end
      PG_WAIT: begin
        if (pg_abort) begin
          state_d = OFF_WAIT;
          cnt_d   = '0;
        end else if (pg_done || pg_tmo) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OFF_WAIT: begin
        if (off_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values: sequencing step, then brown-out overrides, then sticky faults.
  always_comb begin
    en_d      = en_q;
    settled_d = settled_q;
    fault_set = '0;
    case (state_q)
      IDLE: begin
        if (|off_set) begin
          en_d[off_idx]      = 1'b0;
          settled_d[off_idx] = 1'b0;
        end else if (|on_set) begin
          en_d[on_idx] = 1'b1;
        end
      end
      PG_WAIT: begin
        if (pg_abort) begin
          en_d[k_q] = 1'b0;
        end else if (pg_done) begin
          settled_d[k_q] = 1'b1;
        end else if (pg_tmo) begin
          en_d[k_q]      = 1'b0;
          fault_set[k_q] = 1'b1;
        end
      end
      default: ;
    endcase
    // A settled channel losing power-good is shut off regardless of FSM state.
    en_d      = en_d & ~brownout;
    settled_d = settled_d & ~brownout;
    fault_set = fault_set | brownout;
    // A new fault wins over a clear arriving in the same cycle.
    fault_d   = (fault_q & ~bus.fault_clr_i) | fault_set;
    irq_d     = |fault_set;
  end

  // Registered outputs; reset drops every enable immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en_q      <= '0;
      settled_q <= '0;
      fault_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      settled_q <= settled_d;
      fault_q   <= fault_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.en_o      = en_q;
  assign bus.settled_o = settled_q;
  assign bus.fault_o   = fault_q;
  assign bus.irq_o     = irq_q;
  assign bus.busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_ldo_power_sequencer.sv
// Directed bench for ldo_power_sequencer with a simple regulator model (pgood follows en after 10 cycles).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_ldo_power_sequencer;
  localparam int N      = 3;
  localparam int S      = 16;
  localparam int PT     = 60;
  localparam int PG_DLY = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldo_power_sequencer_if #(.N_LDO(N)) bus ();

  ldo_power_sequencer #(
    .N_LDO(N), .STAGGER_CYC(S), .PG_TIMEOUT(PT), .CNT_W(16)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  // Regulator model: power-good follows enable after PG_DLY cycles unless the channel is marked bad.
  logic [N-1:0] pg_ok = '1;
  logic [PG_DLY-1:0][N-1:0] en_hist = '0;
  always @(posedge clk) en_hist <= {en_hist[PG_DLY-2:0], bus.en_o};
  assign bus.pgood_i = en_hist[PG_DLY-1] & pg_ok;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] pg;
    int           n;
    logic [N-1:0] en;
    logic [N-1:0] settled;
    logic [N-1:0] fault;
    logic         busy;
    logic         irq;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles until en_o[ch] reaches val, bounded by budget.
  task automatic wait_en(input int ch, input logic val, input int budget, output int n);
    n = 0;
    while (bus.en_o[ch] !== val && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bus.req_i       = '0;
    bus.fault_clr_i = '0;

    // Reset state.
    tick(3);
    chk("rst_en", bus.en_o, 3'b000);
    chk("rst_busy", bus.busy_o, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("idle_en", bus.en_o, 3'b000);
    chk("idle_settled", bus.settled_o, 3'b000);
    chk("idle_fault", bus.fault_o, 3'b000);
    chk("idle_irq", bus.irq_o, 1'b0);

    // Power-up of all channels, in order 0,1,2 with S+1 spacing.
    bus.req_i = 3'b111;
    wait_en(0, 1'b1, 5, n);   chk("up0_lat", n, 1);
    wait_en(1, 1'b1, 40, n);  chk("up1_gap", n, S + 1);
    wait_en(2, 1'b1, 40, n);  chk("up2_gap", n, S + 1);
    tick(20);
    chk("up_settled", bus.settled_o, 3'b111);
    chk("up_fault", bus.fault_o, 3'b000);
    chk("up_busy", bus.busy_o, 1'b0);

    // Power-down in order 2,1,0; each OFF_WAIT lasts S cycles.
    bus.req_i = 3'b000;
    wait_en(2, 1'b0, 5, n);   chk("dn2_lat", n, 1);
    wait_en(1, 1'b0, 40, n);  chk("dn1_gap", n, S + 1);
    wait_en(0, 1'b0, 40, n);  chk("dn0_gap", n, S + 1);
    n = 0;
    while (bus.busy_o && n < 40) begin
      tick(1);
      n++;
    end
    chk("dn_offwait_len", n, S);
    chk("dn_settled", bus.settled_o, 3'b000);
    chk("dn_fault", bus.fault_o, 3'b000);

    // Timeout on channel 1; a clear in the fault cycle loses to the fault.
    pg_ok = 3'b101;
    bus.req_i = 3'b010;
    wait_en(1, 1'b1, 5, n);   chk("tmo_rise", n, 1);
    tick(PT - 1);
    chk("tmo_still_on", bus.en_o[1], 1'b1);
    bus.fault_clr_i = 3'b010;
    tick(1);
    bus.fault_clr_i = 3'b000;
    chk("tmo_en_drop", bus.en_o[1], 1'b0);
    chk("tmo_fault_wins", bus.fault_o, 3'b010);
    chk("tmo_irq", bus.irq_o, 1'b1);
    tick(1);
    chk("tmo_irq_pulse", bus.irq_o, 1'b0);
    tick(30);
    chk("tmo_held_off", bus.en_o, 3'b000);
    chk("tmo_held_busy", bus.busy_o, 1'b0);
    pg_ok = 3'b111;
    bus.fault_clr_i = 3'b010;
    tick(1);
    bus.fault_clr_i = 3'b000;
    chk("clr_fault", bus.fault_o, 3'b000);
    chk("clr_en_still_off", bus.en_o, 3'b000);
    wait_en(1, 1'b1, 5, n);   chk("clr_reseq", n, 1);
    tick(20);
    chk("clr_settled", bus.settled_o, 3'b010);

    // Brown-out on channel 0 while channel 1 stays settled.
    bus.req_i = 3'b011;
    wait_en(0, 1'b1, 5, n);   chk("bo_rise", n, 1);
    tick(20);
    chk("bo_settled", bus.settled_o, 3'b011);
    pg_ok = 3'b110;
    wait_en(0, 1'b0, 10, n);  chk("bo_lat", n, 3);
    chk("bo_fault", bus.fault_o, 3'b001);
    chk("bo_irq", bus.irq_o, 1'b1);
    chk("bo_settled_after", bus.settled_o, 3'b010);
    chk("bo_en_after", bus.en_o, 3'b010);
    tick(1);
    chk("bo_irq_pulse", bus.irq_o, 1'b0);
    tick(5);
    chk("bo_no_reenable", bus.en_o, 3'b010);
    chk("bo_busy", bus.busy_o, 1'b0);

    // Abort of channel 2 at PG_WAIT cnt=20.
    bus.req_i = 3'b010;
    pg_ok = 3'b011;
    bus.fault_clr_i = 3'b001;
    tick(1);
    bus.fault_clr_i = 3'b000;
    chk("ab_clr", bus.fault_o, 3'b000);
    bus.req_i = 3'b110;
    wait_en(2, 1'b1, 5, n);   chk("ab_rise", n, 1);
    tick(20);
    bus.req_i = 3'b010;
    tick(1);
    chk("ab_en", bus.en_o, 3'b010);
    chk("ab_busy", bus.busy_o, 1'b1);
    chk("ab_fault", bus.fault_o, 3'b000);
    chk("ab_irq", bus.irq_o, 1'b0);
    tick(S - 1);
    chk("ab_offwait_busy", bus.busy_o, 1'b1);
    tick(1);
    chk("ab_offwait_done", bus.busy_o, 1'b0);

    // Reset asserted mid PG_WAIT clears outputs without a clock edge.
    bus.req_i = 3'b110;
    wait_en(2, 1'b1, 5, n);   chk("ar_rise", n, 1);
    tick(5);
    rst = 1'b1;
    #1;
    chk("ar_en", bus.en_o, 3'b000);
    chk("ar_settled", bus.settled_o, 3'b000);
    chk("ar_busy", bus.busy_o, 1'b0);
    chk("ar_fault", bus.fault_o, 3'b000);
    bus.req_i = 3'b000;
    pg_ok = 3'b111;
    tick(12);
    rst = 1'b0;

    // Table: steady-state sequencing snapshots with hand-computed results.
    //           req     pg      n   en      settled fault   busy  irq
    vt[0]  = '{3'b000, 3'b111, 3,  3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[1]  = '{3'b100, 3'b111, 1,  3'b100, 3'b000, 3'b000, 1'b1, 1'b0};
    vt[2]  = '{3'b100, 3'b111, 16, 3'b100, 3'b100, 3'b000, 1'b0, 1'b0};
    vt[3]  = '{3'b101, 3'b111, 1,  3'b101, 3'b100, 3'b000, 1'b1, 1'b0};
    vt[4]  = '{3'b101, 3'b111, 17, 3'b101, 3'b101, 3'b000, 1'b0, 1'b0};
    vt[5]  = '{3'b001, 3'b111, 1,  3'b001, 3'b001, 3'b000, 1'b1, 1'b0};
    vt[6]  = '{3'b001, 3'b111, 15, 3'b001, 3'b001, 3'b000, 1'b1, 1'b0};
    vt[7]  = '{3'b001, 3'b111, 1,  3'b001, 3'b001, 3'b000, 1'b0, 1'b0};
    vt[8]  = '{3'b010, 3'b111, 1,  3'b000, 3'b000, 3'b000, 1'b1, 1'b0};
    vt[9]  = '{3'b010, 3'b111, 16, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[10] = '{3'b010, 3'b111, 1,  3'b010, 3'b000, 3'b000, 1'b1, 1'b0};
    vt[11] = '{3'b000, 3'b111, 1,  3'b000, 3'b000, 3'b000, 1'b1, 1'b0};
    vt[12] = '{3'b000, 3'b111, 16, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      bus.req_i = vt[i].req;
      pg_ok     = vt[i].pg;
      tick(vt[i].n);
      chk($sformatf("vec%0d_en", i), bus.en_o, vt[i].en);
      chk($sformatf("vec%0d_settled", i), bus.settled_o, vt[i].settled);
      chk($sformatf("vec%0d_fault", i), bus.fault_o, vt[i].fault);
      chk($sformatf("vec%0d_busy", i), bus.busy_o, vt[i].busy);
      chk($sformatf("vec%0d_irq", i), bus.irq_o, vt[i].irq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
